instr_fetch: RTL and testbench

Instruction fetch stage for the RIU core. It holds the program counter and an internal instruction memory. Each cycle it presents one 32-bit instruction word plus its byte PC to the instruction decoder directly downstream. It supports stall, branch/jump redirect with flush, program loading, and halting on `ebreak`.

---
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: program counter, instruction memory and IDLE/RUN/HALT control
// for the RIU fetch stage. One registered instruction word per cycle goes to
// the decoder.
//
// Handshake: instr/pc_out are qualified by instr_valid. The decoder drives
// stall as an inverted ready. While stall is high, every fetch output is
// frozen. A word is consumed on the first edge where instr_valid=1 and
// stall=0. redirect overrides stall and always produces one bubble
// (instr_valid=0) before the target word is presented.
module instr_fetch #(
  parameter int          DEPTH = 4096,
  parameter logic [31:0] NOP   = 32'h0000_0013,
  localparam int         AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic [31:0]   instr,
  output logic [31:0]   pc_out,
  output logic          instr_valid,
  output logic          halted,
  output logic [31:0]   fetch_count,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic [31:0]   mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pc_out_q, pc_out_d;
  logic          valid_q, valid_d;
  logic [31:0]   fetch_count_q, fetch_count_d;

  logic [31:0]   fetch_word;
  logic [AW-1:0] redirect_word;

  // Only the word-address bits of the redirect target select a word.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^{redirect_pc[31:AW+2], redirect_pc[1:0]};

  assign redirect_word = redirect_pc[AW+1:2];
  // Combinational read so a load that lands while stalled is seen by the next fetch.
  assign fetch_word    = mem[pc_q];

  // Next-state and fetch datapath decisions.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    valid_d       = valid_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      S_IDLE: begin
        if (start)    state_d = S_RUN;
        if (redirect) pc_d    = redirect_word;
      end
      S_RUN: begin
        if (redirect) begin
          pc_d    = redirect_word;
          instr_d = NOP;
          valid_d = 1'b0;
        end else if (stall || load_en) begin
          // hold everything; a load this cycle is picked up by the next fetch
        end else if (fetch_word == EBREAK) begin
          state_d = S_HALT;
          instr_d = NOP;
          valid_d = 1'b0;
        end else begin
          instr_d       = fetch_word;
          pc_out_d      = {{(30-AW){1'b0}}, pc_q, 2'b00};
          valid_d       = 1'b1;
          pc_d          = pc_q + AW'(1);
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      S_HALT: begin
        // locked until reset
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_q       <= NOP;
      pc_out_q      <= '0;
      valid_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      valid_q       <= valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Program load port; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en && !rst) mem[load_addr] <= load_data;
  end

  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == S_HALT);
  assign fetch_count = fetch_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a DEPTH=16 instance for fetch, stall,
// redirect, halt and reset behaviour, and a DEPTH=4 instance for PC wrap.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance (DEPTH=16)
  logic        start, stall, redirect, load_en;
  logic [31:0] redirect_pc, load_data;
  logic [3:0]  load_addr;
  logic [31:0] instr, pc_out, fetch_count;
  logic        instr_valid, halted;
  logic [1:0]  dbg_state;

  // wrap instance (DEPTH=4)
  logic        w_start, w_stall, w_redirect, w_load_en;
  logic [31:0] w_redirect_pc, w_load_data;
  logic [1:0]  w_load_addr;
  logic [31:0] w_instr, w_pc_out, w_fetch_count;
  logic        w_instr_valid, w_halted;
  logic [1:0]  w_dbg_state;

  instr_fetch #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .instr(instr), .pc_out(pc_out), .instr_valid(instr_valid),
    .halted(halted), .fetch_count(fetch_count), .dbg_state(dbg_state)
  );

  instr_fetch #(.DEPTH(4)) dut_w (
    .clk(clk), .rst(rst), .start(w_start), .stall(w_stall),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .load_en(w_load_en), .load_addr(w_load_addr), .load_data(w_load_data),
    .instr(w_instr), .pc_out(w_pc_out), .instr_valid(w_instr_valid),
    .halted(w_halted), .fetch_count(w_fetch_count), .dbg_state(w_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prog [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_instr"}, instr, NOP);
    check_eq({tag, "_pc"}, pc_out, 32'h0);
    check_eq({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
    check_eq({tag, "_halted"}, {31'b0, halted}, 32'h0);
    check_eq({tag, "_count"}, fetch_count, 32'h0);
  endtask

  // Start from IDLE and run to the first valid word (mem[0]).
  task automatic start_and_first_fetch();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    start = 0; stall = 0; redirect = 0; load_en = 0;
    redirect_pc = '0; load_data = '0; load_addr = '0;
    w_start = 0; w_stall = 0; w_redirect = 0; w_load_en = 0;
    w_redirect_pc = '0; w_load_data = '0; w_load_addr = '0;
    rst = 0;
    prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3; prog[3] = 32'h0010_0073;

    do_reset();
    check_reset_outputs("reset");
    check_eq("reset_state", {30'b0, dbg_state}, 32'd0);

    for (int i = 0; i < 4; i++) load_word(4'(i), prog[i]);
    load_word(4'd8, 32'h0000_0033);
    load_word(4'd9, 32'h0010_0073);
    check_reset_outputs("idle_after_load");

    // Sequential fetch with a 3-cycle stall after the first word.
    start_and_first_fetch();
    check_eq("seq0_instr", instr, prog[0]);
    check_eq("seq0_pc", pc_out, 32'h0);
    check_eq("seq0_valid", {31'b0, instr_valid}, 32'h1);
    check_eq("seq0_count", fetch_count, 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_instr", instr, prog[0]);
      check_eq("stall_pc", pc_out, 32'h0);
      check_eq("stall_count", fetch_count, 32'd1);
    end
    stall = 1'b0;
    exp_q.push_back(prog[1]);
    exp_q.push_back(prog[2]);
    for (int i = 1; i < 3; i++) begin
      tick();
      check_eq("seq_instr", instr, exp_q.pop_front());
      check_eq("seq_pc", pc_out, 32'(i * 4));
      check_eq("seq_valid", {31'b0, instr_valid}, 32'h1);
    end
    tick();
    check_eq("halt_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("halt_instr", instr, NOP);
    check_eq("halt_halted", {31'b0, halted}, 32'h1);
    check_eq("halt_count", fetch_count, 32'd3);

    // HALT ignores redirect/start/stall.
    redirect = 1'b1; redirect_pc = 32'h0; start = 1'b1; stall = 1'b1;
    tick(); tick();
    redirect = 1'b0; start = 1'b0; stall = 1'b0;
    tick();
    check_eq("lock_halted", {31'b0, halted}, 32'h1);
    check_eq("lock_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("lock_instr", instr, NOP);
    check_eq("lock_count", fetch_count, 32'd3);

    do_reset();
    check_reset_outputs("reset_from_halt");

    // Redirect while fetching.
    start_and_first_fetch();
    redirect = 1'b1; redirect_pc = 32'h0000_0020;
    tick();
    redirect = 1'b0;
    check_eq("redir_bubble_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("redir_bubble_instr", instr, NOP);
    tick();
    check_eq("redir_instr", instr, 32'h0000_0033);
    check_eq("redir_pc", pc_out, 32'h20);
    check_eq("redir_valid", {31'b0, instr_valid}, 32'h1);
    check_eq("redir_count", fetch_count, 32'd2);

    // Redirect beats a simultaneous stall.
    do_reset();
    start_and_first_fetch();
    redirect = 1'b1; redirect_pc = 32'h0000_0020; stall = 1'b1;
    tick();
    redirect = 1'b0; stall = 1'b0;
    check_eq("rs_bubble_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("rs_bubble_instr", instr, NOP);
    tick();
    check_eq("rs_instr", instr, 32'h0000_0033);
    check_eq("rs_pc", pc_out, 32'h20);

    // Redirect with start in IDLE sets the start PC; high and low bits ignored.
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFA3; start = 1'b1;
    tick();
    redirect = 1'b0; start = 1'b0;
    check_eq("idle_redir_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    check_eq("idle_redir_instr", instr, 32'h0000_0033);
    check_eq("idle_redir_pc", pc_out, 32'h20);

    // Reset mid-run, then refetch the program.
    do_reset();
    start_and_first_fetch();
    tick();
    check_eq("mid_pre_pc", pc_out, 32'h4);
    start = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
    do_reset();
    start = 1'b0; redirect = 1'b0;
    check_reset_outputs("reset_mid_run");
    start_and_first_fetch();
    check_eq("refetch0_instr", instr, prog[0]);
    check_eq("refetch0_pc", pc_out, 32'h0);
    tick();
    check_eq("refetch1_instr", instr, prog[1]);
    check_eq("refetch1_pc", pc_out, 32'h4);

    // Load to the current pc while stalled is seen by the next fetch.
    stall = 1'b1;
    load_word(4'd2, 32'h1234_5013);
    stall = 1'b0;
    check_eq("raw_hold_pc", pc_out, 32'h4);
    tick();
    check_eq("raw_instr", instr, 32'h1234_5013);
    check_eq("raw_pc", pc_out, 32'h8);
    check_eq("raw_count", fetch_count, 32'd3);

    // Wrap on the DEPTH=4 instance.
    for (int i = 0; i < 4; i++) begin
      w_load_en = 1'b1; w_load_addr = 2'(i); w_load_data = 32'h0000_1000 + 32'(i);
      tick();
    end
    w_load_en = 1'b0;
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'((i % 4) * 4));
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("wrap_pc", w_pc_out, exp_q.pop_front());
      check_eq("wrap_instr", w_instr, 32'h0000_1000 + 32'(i % 4));
    end
    check_eq("wrap_count", w_fetch_count, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
